// File: rtl/key_expander.sv
// ---------------------------------------------------------------------------
// key_expander
//   Iterative AES key schedule for AES-128/192/256 (KeySize chosen at
//   elaboration). One 32-bit schedule word is produced per clock from an
//   Nk-word sliding window; every fourth word completes a 128-bit round key,
//   which is presented on a valid/ready stream together with its round number.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     pulse, loads key_in and starts expansion (ignored while busy)
//   abort     synchronous cancel, returns to idle and scrubs key state
//   key_in    cipher key, word i at [32i+31:32i], byte 0 of a word at [31:24]
//   busy      expansion in progress (start through acceptance of last key)
//   rk_valid  rk_data/rk_index/rk_last hold a round key
//   rk_ready  consumer accepts the round key on this edge
//   rk_data   round key r, word 4r at [31:0]
//   rk_index  round number r (0..Nr)
//   rk_last   high with rk_valid for round Nr
//   done      one-cycle pulse after the final round key is accepted
// ---------------------------------------------------------------------------

// AES S-box, computed as multiplicative inverse in GF(2^8) followed by the
// affine transform. Shared by all word-rule cases through four instances.
module key_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] m;
        logic [7:0] n;
        p = 8'h00;
        m = x;
        n = z;
        for (int i = 0; i < 8; i++) begin
            if (n[0]) p = p ^ m;
            m = xtime(m);
            n = {1'b0, n[7:1]};
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0, and 0 maps to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] acc;
        s   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s   = gf_mul(s, s);
            acc = gf_mul(acc, s);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

module key_expander #(
    parameter int KeySize = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [KeySize-1:0] key_in,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [127:0]       rk_data,
    output logic [3:0]         rk_index,
    output logic               rk_last,
    output logic               done
);

    localparam int Nk    = KeySize / 32;
    localparam int Nr    = Nk + 6;
    localparam int TOTAL = 4 * (Nr + 1);

    localparam logic [5:0] NK6    = 6'(Nk);
    localparam logic [5:0] LAST_J = 6'(TOTAL - 1);
    localparam logic [2:0] NK_M1  = 3'(Nk - 1);
    localparam logic [3:0] NR4    = 4'(Nr);

    generate
        if (KeySize != 128 && KeySize != 192 && KeySize != 256) begin : g_bad_key_size
            $error("key_expander: KeySize must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t state_q, state_n;

    // Schedule state: j counts words, jm tracks j mod Nk so no divider is needed.
    logic [5:0]            j_q;
    logic [2:0]            jm_q;
    logic [7:0]            rcon_q;
    logic [Nk-1:0][31:0]   win_q;     // win_q[Nk-1] = w[j-1], win_q[0] = w[j-Nk]
    logic [2:0][31:0]      word_buf;  // words 4r..4r+2 of the round in flight

    logic                  gen_en;
    logic                  start_ok;
    logic                  finish;
    logic                  xfer;

    logic [31:0]           prev_w;
    logic [31:0]           old_w;
    logic [31:0]           key_w;
    logic [31:0]           new_w;
    logic                  sub_path;
    logic [3:0][7:0]       sb_in;
    logic [3:0][7:0]       sb_out;
    logic [Nk-1:0][31:0]   win_sh;

    assign xfer = rk_valid && rk_ready;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        gen_en   = 1'b0;
        start_ok = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_n  = GEN;
                end
            end
            GEN: begin
                // Only the word that completes a round key must wait for the
                // output register; the three buffered words keep flowing.
                gen_en = !((j_q[1:0] == 2'd3) && rk_valid && !rk_ready);
                if (gen_en && (j_q == LAST_J)) state_n = DRAIN;
            end
            DRAIN: begin
                if (xfer) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n  = IDLE;
            gen_en   = 1'b0;
            start_ok = 1'b0;
            finish   = 1'b0;
        end
    end

    // ---------------- word generation ----------------
    assign prev_w   = win_q[Nk-1];
    assign old_w    = win_q[0];
    assign sub_path = (Nk == 8) && (jm_q == 3'd4);
    // Plain SubWord for the AES-256 mid-block word, SubWord(RotWord) otherwise.
    assign sb_in    = sub_path ? prev_w : {prev_w[23:0], prev_w[31:24]};

    key_sbox u_sbox [3:0] (
        .a (sb_in),
        .y (sb_out)
    );

    always_comb begin
        // While j < Nk the window still holds the raw key unshifted, so key
        // word j sits at window slot jm (== j).
        key_w = '0;
        for (int i = 0; i < Nk; i++) begin
            if (jm_q == 3'(i)) key_w = win_q[i];
        end

        if (j_q < NK6)            new_w = key_w;
        else if (jm_q == 3'd0)    new_w = old_w ^ sb_out ^ {rcon_q, 24'h0};
        else if (sub_path)        new_w = old_w ^ sb_out;
        else                      new_w = old_w ^ prev_w;

        win_sh = win_q;
        for (int i = 0; i < Nk - 1; i++) begin
            win_sh[i] = win_q[i + 1];
        end
        win_sh[Nk-1] = new_w;
    end

    // ---------------- datapath / outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q      <= '0;
            jm_q     <= '0;
            rcon_q   <= 8'h01;
            win_q    <= '0;
            word_buf <= '0;
            rk_data  <= '0;
            rk_index <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (abort) begin
                // Scrub all retained key material and drop the stream.
                j_q      <= '0;
                jm_q     <= '0;
                rcon_q   <= 8'h01;
                win_q    <= '0;
                word_buf <= '0;
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                if (start_ok) begin
                    win_q  <= key_in;
                    j_q    <= '0;
                    jm_q   <= '0;
                    rcon_q <= 8'h01;
                    busy   <= 1'b1;
                end

                if (xfer) begin
                    rk_valid <= 1'b0;
                    rk_last  <= 1'b0;
                end

                if (finish) busy <= 1'b0;

                if (gen_en) begin
                    j_q  <= j_q + 6'd1;
                    jm_q <= (jm_q == NK_M1) ? 3'd0 : jm_q + 3'd1;
                    if (j_q >= NK6) begin
                        win_q <= win_sh;
                        if (jm_q == 3'd0)
                            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end
                    case (j_q[1:0])
                        2'd0: word_buf[0] <= new_w;
                        2'd1: word_buf[1] <= new_w;
                        2'd2: word_buf[2] <= new_w;
                        default: begin
                            // Completing word: load the full round key. This
                            // overrides a same-edge transfer so there is no bubble.
                            rk_data  <= {new_w, word_buf[2], word_buf[1], word_buf[0]};
                            rk_index <= j_q[5:2];
                            rk_valid <= 1'b1;
                            rk_last  <= (j_q[5:2] == NR4);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_key_expander.sv
module tb_key_expander;

    localparam logic [127:0] K128   = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] ALT128 = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
    localparam logic [127:0] R1_128 = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam logic [127:0] R2_128 = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
    localparam logic [127:0] R10_128 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] R12_192 = {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f};
    localparam logic [127:0] R14_256 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};

    logic clk;
    logic rst;
    logic [2:0] start_s;
    logic [2:0] abort_s;
    logic [2:0] rdy;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    wire [2:0]        busy_o;
    wire [2:0]        vld_o;
    wire [2:0]        last_o;
    wire [2:0]        done_o;
    wire [2:0][127:0] data_o;
    wire [2:0][3:0]   idx_o;

    logic [127:0] got      [3][15];
    int           got_t    [3][15];
    logic         got_last [3][15];

    int n_chk = 0;
    int n_err = 0;

    key_expander #(.KeySize(128)) u_dut128 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .key_in(key128),
        .busy(busy_o[0]), .rk_valid(vld_o[0]), .rk_ready(rdy[0]), .rk_data(data_o[0]),
        .rk_index(idx_o[0]), .rk_last(last_o[0]), .done(done_o[0])
    );

    key_expander #(.KeySize(192)) u_dut192 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .key_in(key192),
        .busy(busy_o[1]), .rk_valid(vld_o[1]), .rk_ready(rdy[1]), .rk_data(data_o[1]),
        .rk_index(idx_o[1]), .rk_last(last_o[1]), .done(done_o[1])
    );

    key_expander #(.KeySize(256)) u_dut256 (
        .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .key_in(key256),
        .busy(busy_o[2]), .rk_valid(vld_o[2]), .rk_ready(rdy[2]), .rk_data(data_o[2]),
        .rk_index(idx_o[2]), .rk_last(last_o[2]), .done(done_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    // Start DUT d, collect every round key, optionally hold off round 0 for
    // 'stall' cycles, optionally fire a second start (different key) mid-run.
    task automatic run_keys(input int d, input int nr, input int stall, input bit poke);
        int n;
        int held;
        logic [3:0] i;
        n    = 0;
        held = 0;
        for (int k = 0; k < 15; k++) begin
            got[d][k]      = '0;
            got_t[d][k]    = -1;
            got_last[d][k] = 1'b0;
        end
        rdy[d]     = 1'b1;
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("busy_set", 128'(busy_o[d]), 128'(1));
        for (int t = 0; t < 400 && n < nr + 1; t++) begin
            if (t == 3) chk("lat_pre", 128'(vld_o[d]), 128'(0));
            if (poke && t == 6) begin
                start_s[d] = 1'b1;
                key128     = ALT128;
            end
            if (poke && t == 7) start_s[d] = 1'b0;
            if (stall > 0 && vld_o[d] && idx_o[d] == 4'd0 && held < stall) begin
                rdy[d] = 1'b0;
                chk("stall_hold", data_o[d], K128);
                held++;
            end else begin
                rdy[d] = 1'b1;
            end
            if (vld_o[d] && rdy[d]) begin
                i              = idx_o[d];
                got[d][i]      = data_o[d];
                got_t[d][i]    = t;
                got_last[d][i] = last_o[d];
                n++;
            end
            @(negedge clk);
        end
        chk("key_count", 128'(n), 128'(nr + 1));
        chk("done_pulse", 128'({vld_o[d], busy_o[d], done_o[d]}), 128'(3'b001));
        @(negedge clk);
        chk("done_clear", 128'(done_o[d]), 128'(0));
        key128 = K128;
    endtask

    task automatic chk_aes128(input string pfx);
        chk({pfx, "_r0"}, got[0][0], K128);
        chk({pfx, "_r1"}, got[0][1], R1_128);
        chk({pfx, "_r2"}, got[0][2], R2_128);
        chk({pfx, "_r10"}, got[0][10], R10_128);
        chk({pfx, "_last10"}, 128'(got_last[0][10]), 128'(1));
        chk({pfx, "_last9"}, 128'(got_last[0][9]), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic seen;
        rst     = 1'b1;
        start_s = '0;
        abort_s = '0;
        rdy     = 3'b111;
        key128  = K128;
        key192  = {32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
        key256  = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_flags", 128'({busy_o[d], vld_o[d], last_o[d], done_o[d]}), 128'(0));
            chk("rst_data", data_o[d], 128'(0));
            chk("rst_index", 128'(idx_o[d]), 128'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        // AES-128 straight run with an ignored second start mid-generation
        run_keys(0, 10, 0, 1'b1);
        chk_aes128("a128");
        chk("a128_t0", 128'(got_t[0][0]), 128'(4));
        chk("a128_t1", 128'(got_t[0][1]), 128'(8));
        chk("a128_t10", 128'(got_t[0][10]), 128'(44));
        chk("a128_hold_data", data_o[0], R10_128);

        // AES-192
        run_keys(1, 12, 0, 1'b0);
        chk("a192_r0", got[1][0], key192[127:0]);
        chk("a192_r12", got[1][12], R12_192);
        chk("a192_last12", 128'(got_last[1][12]), 128'(1));
        chk("a192_t12", 128'(got_t[1][12]), 128'(52));

        // AES-256 (exercises the SubWord-only word)
        run_keys(2, 14, 0, 1'b0);
        chk("a256_r0", got[2][0], key256[127:0]);
        chk("a256_r1", got[2][1], key256[255:128]);
        chk("a256_r14", got[2][14], R14_256);
        chk("a256_last14", 128'(got_last[2][14]), 128'(1));

        // Backpressure on round 0 for 10 cycles
        run_keys(0, 10, 10, 1'b0);
        chk_aes128("stall");
        chk("stall_t0", 128'(got_t[0][0]), 128'(14));
        chk("stall_t1", 128'(got_t[0][1]), 128'(15));

        // Abort in the middle of round 5
        rdy[0]     = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int t = 0; t < 22; t++) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort_flags", 128'({busy_o[0], vld_o[0], last_o[0], done_o[0]}), 128'(0));
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            seen = seen | done_o[0] | vld_o[0] | busy_o[0];
        end
        chk("abort_quiet", 128'(seen), 128'(0));
        run_keys(0, 10, 0, 1'b0);
        chk_aes128("post_abort");

        // Asynchronous reset between clock edges mid-expansion
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int t = 0; t < 10; t++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_flags", 128'({busy_o[0], vld_o[0], last_o[0], done_o[0]}), 128'(0));
        chk("arst_data", data_o[0], 128'(0));
        chk("arst_index", 128'(idx_o[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", 128'({busy_o[0], vld_o[0]}), 128'(0));
        run_keys(0, 10, 0, 1'b0);
        chk_aes128("post_rst");
        chk("post_rst_t10", 128'(got_t[0][10]), 128'(44));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/key_expander.md
Name: key_expander

Overview:
- Iterative AES key expansion engine for AES-128/192/256, selected at elaboration by KeySize.
- Captures a cipher key on a start pulse and generates one 32-bit schedule word per clock.
- Streams the Nr+1 round keys, 128 bits each, in order over a valid/ready interface with backpressure.
- Sits between key load and the round datapath; replaces the single-round, AES-128-only combinational schedule step.

Parameters:
- KeySize, 128, cipher key width in bits. Legal values are 128/192/256; any other value is an elaboration error.
- Derived, not overridable: Nk = KeySize/32 (4/6/8); Nr = Nk+6 (10/12/14); total words = 4*(Nr+1) (44/52/60).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; loads key_in and begins expansion (honoured only when busy=0)
- abort  in  1  synchronous cancel; returns to idle
- key_in  in  KeySize  cipher key; word i at bits [32i+31:32i]; within a word byte 0 at [31:24]
- busy  out  1  expansion in progress (start through acceptance of last key)
- rk_valid  out  1  rk_data holds a round key
- rk_ready  in  1  consumer accepts; transfer occurs when rk_valid and rk_ready are both high on a rising edge
- rk_data  out  128  round key; words 4r..4r+3 packed as key_in (word 4r at [31:0])
- rk_index  out  4  round number r of rk_data (0..Nr)
- rk_last  out  1  high with rk_valid when rk_index == Nr
- done  out  1  one-cycle pulse on the edge after the last round key is accepted

Behaviour:
- Reset: asynchronous; all state clears. busy, rk_valid, rk_last, done = 0; rk_data = 0; rk_index = 0; word counter = 0; rcon = 8'h01.
- Reset mid-operation: the expansion is discarded; the block is idle after reset release.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE: start=1 captures key_in, sets busy, resets word counter j=0 and rcon=01, enters GEN.
  - GEN: produces word w[j] at each edge it is not stalled.
  - DRAIN: entered when w[total-1] is loaded into the output register; waits for acceptance of round Nr, then pulses done, clears busy and returns to IDLE.
- Word rule:
  - j < Nk: w[j] is key word j.
  - j mod Nk == 0: w[j] = w[j-Nk] ^ SubWord(RotWord(w[j-1])) ^ {rcon,24'h0}. RotWord is {w[23:0], w[31:24]}. rcon then updates to xtime(rcon) (01,02,...,80,1b,36,...).
  - Nk == 8 and j mod 8 == 4: w[j] = w[j-8] ^ SubWord(w[j-1]).
  - Otherwise: w[j] = w[j-Nk] ^ w[j-1].
  - Implementation holds an Nk-word sliding window; the team S-box module provides four lookups shared across all cases.
- Assembly:
  - Words 4r..4r+2 accumulate in a 3-word buffer.
  - Word 4r+3 is computed and loaded, together with the buffer, into rk_data on the same edge; rk_index = r and rk_valid = 1 are set on that edge.
- Stall: word 4r+3 is not generated (j holds, window holds) while rk_valid=1 and rk_ready=0. Words 4r..4r+2 are still generated during the stall.
- Latency and throughput:
  - With start sampled at edge E0, round key 0 is valid after edge E4.
  - With rk_ready held high, one round key every 4 cycles; the last key is valid 4*(Nr+1) cycles after E0.
  - After a stall, accepting round r and loading round r+1 happen on the same edge, so rk_valid stays high with no bubble.
- rk_data, rk_index and rk_last are stable while rk_valid=1 and rk_ready=0.
- After the final transfer: rk_valid = 0 and rk_data holds its last value.
- start while busy=1 is ignored; key_in is sampled only on an accepted start.
- abort:
  - Takes effect at the next edge from any state; abort has priority over start and over a simultaneous transfer.
  - Clears rk_valid, rk_last and busy and returns to IDLE; no done pulse.
  - The window and buffer are zeroed so no key material is retained.

Test Plan:
- AES-128 (FIPS-197 A.1), key_in = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516, rk_ready=1 → 11 keys at 4-cycle spacing. Round 1 words = a0fafe17, 88542cb1, 23a33939, 2a6c7605. Round 10 = d014f9a8, c9ee2589, e13f0cc8, b6630ca6 with rk_last=1, followed by done.
- AES-192 (FIPS-197 A.2), key words 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → 13 keys. Round 12 words = e98ba06f, 448c773c, 8ecc7204, 01002202; rk_index=12.
- AES-256 (FIPS-197 A.3), key words 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → round 14 words = fe4890d1, e6188d0b, 046df344, 706c631e. This exercises the j mod 8 == 4 SubWord path.
- Backpressure: rk_ready held low for 10 cycles after round 0 is valid → rk_data stable throughout; round 1 presented on the edge that accepts round 0; final keys identical to the no-stall run.
- A start pulse during GEN with a different key_in is ignored (outputs match the first key). abort asserted mid-round-5 → rk_valid=0 and busy=0 next cycle, no done. A fresh start then yields correct round 0.
- rst asserted asynchronously mid-expansion (between clock edges) → all outputs 0 immediately. Expansion after release matches the AES-128 vectors.
